sram_controller: RTL and testbench
==================================

SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 Parameters SHALL be, one per line:
- N, 32, CPU data word width.
- SRAM_W, 16, SRAM data bus width.
- ADDR_W, 18, SRAM halfword address width.
- WAIT, 2, clock cycles each SRAM halfword access is held; legal range 1..15.
- BASE, 1024, CPU byte address that maps to SRAM word 0.

REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- MEM_R_EN  in  1  load request from the EXE/MEM side.
- MEM_W_EN  in  1  store request.
- Address  in  N  CPU byte address (ALU result).
- WriteData  in  N  store data.
- ReadData  out  N  assembled load data; this is the DataMemoryIn source of the MEM/WB register.
- ready  out  1  access complete; the pipeline freeze is !ready.
- SRAM_ADDR  out  ADDR_W  halfword address.
- SRAM_DQ_OUT  out  SRAM_W  write data to the SRAM.
- SRAM_DQ_OE  out  1  drive enable for SRAM_DQ_OUT.
- SRAM_DQ_IN  in  SRAM_W  read data from the SRAM.
- SRAM_WE_N  out  1  write strobe, active-low.

Function
REQ-003 The FSM SHALL have four states: IDLE, LOW, HIGH, DONE.
REQ-004 In IDLE, when MEM_W_EN or MEM_R_EN is high, the block SHALL latch Address, WriteData and the op, then go to LOW; when both are high, the write SHALL win.
REQ-005 Word address SHALL be (Address - BASE) >> 2, truncated to ADDR_W-1 bits. The LOW phase SHALL use SRAM_ADDR = {word, 0}; the HIGH phase SHALL use SRAM_ADDR = {word, 1}.
REQ-006 LOW and HIGH SHALL each last exactly WAIT cycles, counted by a 4-bit counter that clears on every state change.
REQ-007 Write: in LOW/HIGH, SRAM_WE_N SHALL be 0, SRAM_DQ_OE SHALL be 1, and SRAM_DQ_OUT SHALL be WriteData[15:0] in LOW and WriteData[31:16] in HIGH.
REQ-008 Read: SRAM_WE_N SHALL be 1 and SRAM_DQ_OE SHALL be 0. SRAM_DQ_IN SHALL be sampled on the last cycle of LOW into ReadData[15:0] and on the last cycle of HIGH into ReadData[31:16].
REQ-009 After HIGH the FSM SHALL go to DONE. DONE SHALL last one cycle and then return to IDLE unconditionally.
REQ-010 ready SHALL be combinational: 1 in DONE, 1 in IDLE with no request, 0 otherwise.
REQ-011 Latency: for a request first seen in IDLE at cycle 0, ready SHALL be 1 at cycle 2*WAIT+1 (cycle 5 for WAIT=2).
REQ-012 Request inputs SHALL be ignored outside IDLE; the pipeline holds them stable while frozen.
REQ-013 ReadData SHALL hold its value until the next read overwrites it; writes SHALL NOT alter it.
REQ-014 Outside LOW/HIGH, SRAM_WE_N SHALL be 1, SRAM_DQ_OE SHALL be 0, and SRAM_ADDR and SRAM_DQ_OUT SHALL be 0.
REQ-015 A request present in IDLE on the cycle right after DONE SHALL be treated as a new access.
REQ-016 Address wrap: an address below BASE SHALL wrap modulo 2^(ADDR_W-1) words, with no error flag.

Reset
REQ-017 When rst is high at a rising edge, state SHALL go to IDLE, the counter SHALL be 0, ReadData and the latched registers SHALL be 0, SRAM_WE_N SHALL be 1 and SRAM_DQ_OE SHALL be 0.
REQ-018 Reset mid-access SHALL abort the access at once; a half-written word SHALL be left as is.
REQ-019 ready SHALL be 1 the cycle after reset when no request is present.

Structure
REQ-020 A shared package SHALL hold the state enum, the WAIT default, the BASE constant and the SRAM_W/ADDR_W widths.
REQ-021 There SHALL be one sub-module, wait_counter: a 4-bit counter with sync clear and a done = (count == WAIT-1) output.

Verification
REQ-022 The bench SHALL cover these scenarios:
- Write Address=1024, WriteData=0xDEADBEEF, WAIT=2 -> SRAM_ADDR=0 with DQ=0xBEEF for 2 cycles, then SRAM_ADDR=1 with DQ=0xDEAD for 2 cycles, WE_N low throughout, ready=1 at cycle 5.
- Read Address=1028 with SRAM model returning 0x5678 at address 2 and 0x1234 at address 3 -> ReadData=0x12345678, ready=1 at cycle 5.
- MEM_R_EN and MEM_W_EN both high -> a write is performed and ReadData is unchanged.
- Back-to-back write then read with the request changed on the cycle after DONE -> two complete 5-cycle accesses, no cycle lost or duplicated.
- rst asserted during HIGH of a write -> next cycle IDLE, WE_N=1, OE=0, ReadData=0, ready=1.
- No request for 10 cycles -> ready stays 1, WE_N stays 1, SRAM_ADDR stays 0.

Source files
------------

// File: rtl/sram_controller_pkg.sv
// Shared widths, timing defaults and FSM state encoding for the SRAM controller.
package sram_controller_pkg;

   localparam int SRAM_W_DEF = 16;
   localparam int ADDR_W_DEF = 18;
   localparam int WAIT_DEF   = 2;
   localparam int BASE_DEF   = 1024;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_LOW  = 2'd1;
   localparam state_t ST_HIGH = 2'd2;
   localparam state_t ST_DONE = 2'd3;

endpackage

// File: rtl/sram_controller_wait_counter.sv
// Phase timer: 4-bit up-counter with synchronous clear; done_o flags the last cycle of a phase.
module wait_counter
   import sram_controller_pkg::*;
#(
   parameter int WAIT = WAIT_DEF
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   output logic done_o
);

   localparam logic [3:0] LAST = 4'(WAIT - 1);

   logic [3:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = clr_i ? 4'd0 : cnt_q + 4'd1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) cnt_q <= 4'd0;
      else       cnt_q <= cnt_d;
   end

   assign done_o = (cnt_q == LAST);

endmodule

// File: rtl/sram_controller.sv
// Splits one 32-bit CPU load/store into two 16-bit SRAM accesses of WAIT cycles each.
// ready drops for 2*WAIT+1 cycles per access and returns high in the single DONE cycle.
module sram_controller
   import sram_controller_pkg::*;
#(
   parameter int N      = 32,
   parameter int SRAM_W = SRAM_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int WAIT   = WAIT_DEF,
   parameter int BASE   = BASE_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              MEM_R_EN,
   input  logic              MEM_W_EN,
   input  logic [N-1:0]      Address,
   input  logic [N-1:0]      WriteData,
   output logic [N-1:0]      ReadData,
   output logic              ready,
   output logic [ADDR_W-1:0] SRAM_ADDR,
   output logic [SRAM_W-1:0] SRAM_DQ_OUT,
   output logic              SRAM_DQ_OE,
   input  logic [SRAM_W-1:0] SRAM_DQ_IN,
   output logic              SRAM_WE_N
);

   localparam int          WORD_W = ADDR_W - 1;
   localparam logic [N-1:0] BASE_V = N'(BASE);

   state_t              state_q, state_d;
   logic                wr_q, wr_d;
   logic [WORD_W-1:0]   word_q, word_d;
   logic [N-1:0]        wdata_q, wdata_d;
   logic [N-1:0]        rdata_q, rdata_d;
   logic                req;
   logic                phase_done;
   logic                cnt_clr;
   logic                active;
   logic                hi;

   assign req = MEM_R_EN | MEM_W_EN;

   always_comb begin
      state_d = state_q;
      wr_d    = wr_q;
      word_d  = word_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      case (state_q)
         ST_IDLE: begin
            if (req) begin
               state_d = ST_LOW;
               wr_d    = MEM_W_EN;
               word_d  = WORD_W'((Address - BASE_V) >> 2);
               wdata_d = WriteData;
            end
         end
         ST_LOW: begin
            if (phase_done) begin
               state_d = ST_HIGH;
               if (!wr_q) rdata_d[SRAM_W-1:0] = SRAM_DQ_IN;
            end
         end
         ST_HIGH: begin
            if (phase_done) begin
               state_d = ST_DONE;
               if (!wr_q) rdata_d[N-1:SRAM_W] = SRAM_DQ_IN;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Counter is held clear outside LOW/HIGH so each phase starts counting from zero.
   assign cnt_clr = (state_d != state_q) || (state_q == ST_IDLE) || (state_q == ST_DONE);

   wait_counter #(.WAIT(WAIT)) u_wait_counter (
      .clk_i  (clk),
      .rst_i  (rst),
      .clr_i  (cnt_clr),
      .done_o (phase_done)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         wr_q    <= 1'b0;
         word_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         wr_q    <= wr_d;
         word_q  <= word_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   assign active      = (state_q == ST_LOW) || (state_q == ST_HIGH);
   assign hi          = (state_q == ST_HIGH);
   assign SRAM_ADDR   = active ? {word_q, hi} : '0;
   assign SRAM_WE_N   = !(active && wr_q);
   assign SRAM_DQ_OE  = active && wr_q;
   assign SRAM_DQ_OUT = (active && wr_q) ? (hi ? wdata_q[N-1:SRAM_W] : wdata_q[SRAM_W-1:0]) : '0;
   assign ready       = (state_q == ST_DONE) || ((state_q == ST_IDLE) && !req);
   assign ReadData    = rdata_q;

endmodule

// File: tb/tb_sram_controller.sv
// Scoreboarded bench for sram_controller with a behavioural SRAM and word-level reference memory.
module tb_sram_controller;

   localparam int WT    = 2;
   localparam int BASE  = 1024;
   localparam int AW    = 18;
   localparam int WORDS = 1 << (AW - 1);

   logic        clk = 1'b0;
   logic        rst;
   logic        MEM_R_EN, MEM_W_EN;
   logic [31:0] Address, WriteData, ReadData;
   logic        ready;
   logic [17:0] SRAM_ADDR;
   logic [15:0] SRAM_DQ_OUT, SRAM_DQ_IN;
   logic        SRAM_DQ_OE, SRAM_WE_N;

   always #5 clk = ~clk;

   sram_controller #(
      .N(32), .SRAM_W(16), .ADDR_W(AW), .WAIT(WT), .BASE(BASE)
   ) dut (
      .clk(clk), .rst(rst), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
      .Address(Address), .WriteData(WriteData), .ReadData(ReadData), .ready(ready),
      .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ_OUT(SRAM_DQ_OUT), .SRAM_DQ_OE(SRAM_DQ_OE),
      .SRAM_DQ_IN(SRAM_DQ_IN), .SRAM_WE_N(SRAM_WE_N)
   );

   // Behavioural asynchronous SRAM: combinational read, write on the clock while strobed.
   logic [15:0] sram    [0:(1 << AW) - 1];
   logic [31:0] ref_mem [0:WORDS - 1];

   assign SRAM_DQ_IN = sram[SRAM_ADDR];

   always @(posedge clk) begin
      if (!SRAM_WE_N && SRAM_DQ_OE) sram[SRAM_ADDR] = SRAM_DQ_OUT;
   end

   typedef struct {
      bit          wr;
      int          word;
      logic [31:0] wd;
      logic [31:0] rd;
   } exp_t;

   typedef struct packed {
      logic [17:0] addr;
      logic        we_n;
      logic        oe;
      logic [15:0] dq;
   } smp_t;

   exp_t        exp_q[$];
   int          tests = 0;
   int          fails = 0;
   logic [31:0] last_rd;

   function automatic logic [15:0] init_hw(int a);
      return 16'((a * 40503) ^ 23130);
   endfunction

   task automatic check(string name, logic [63:0] act, logic [63:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // Bus sample expected i cycles after the request is first seen in IDLE.
   function automatic smp_t exp_smp(exp_t e, int i);
      smp_t s;
      int   half;
      s = {18'd0, 1'b1, 1'b0, 16'd0};
      if (i == 0) return s;
      half   = ((i - 1) >= WT) ? 1 : 0;
      s.addr = 18'(e.word * 2 + half);
      if (e.wr) begin
         s.we_n = 1'b0;
         s.oe   = 1'b1;
         s.dq   = (half == 1) ? e.wd[31:16] : e.wd[15:0];
      end
      return s;
   endfunction

   initial begin : monitor
      smp_t tr[$];
      exp_t e;
      int   bad;
      forever begin
         @(negedge clk);
         if (rst) begin
            tr.delete();
         end else if (!ready) begin
            tr.push_back({SRAM_ADDR, SRAM_WE_N, SRAM_DQ_OE, SRAM_DQ_OUT});
            if (tr.size() > 100) begin
               tests++; fails++;
               $display("FAIL stuck_busy: got %0d busy cycles expected %0d", tr.size(), 2*WT+1);
               tr.delete();
            end
         end else if (tr.size() > 0) begin
            if (exp_q.size() == 0) begin
               tests++; fails++;
               $display("FAIL unexpected_access: got completion expected none");
            end else begin
               e = exp_q.pop_front();
               check("latency", 64'(tr.size()), 64'(2*WT+1));
               bad = -1;
               for (int i = 0; i < tr.size() && i < 2*WT+1; i++)
                  if (bad < 0 && tr[i] !== exp_smp(e, i)) bad = i;
               tests++;
               if (bad >= 0) begin
                  fails++;
                  $display("FAIL bus_trace cycle %0d: got %0h expected %0h", bad, tr[bad], exp_smp(e, bad));
               end
               check("readdata", 64'(ReadData), 64'(e.rd));
               check("done_bus_idle", 64'({SRAM_ADDR, SRAM_WE_N, SRAM_DQ_OE, SRAM_DQ_OUT}),
                     64'({18'd0, 1'b1, 1'b0, 16'd0}));
            end
            tr.delete();
         end
      end
   end

   task automatic wait_done();
      int n;
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!ready && n < 50);
      if (!ready) begin
         tests++; fails++;
         $display("FAIL ready_timeout: got ready=0 expected 1 within 50 cycles");
      end
   endtask

   // Drives a request, records its expected outcome, and returns in the DONE cycle.
   task automatic issue(bit w, bit r, logic [31:0] a, logic [31:0] wd);
      exp_t        e;
      logic [31:0] diff;
      diff        = a - 32'(BASE);
      e.word      = int'((diff / 4) % 32'(WORDS));
      e.wr        = w;
      e.wd        = wd;
      if (w) begin
         ref_mem[e.word] = wd;
         e.rd            = last_rd;
      end else begin
         e.rd    = ref_mem[e.word];
         last_rd = e.rd;
      end
      exp_q.push_back(e);
      MEM_W_EN  = w;
      MEM_R_EN  = r;
      Address   = a;
      WriteData = wd;
      wait_done();
   endtask

   task automatic idle_cycle();
      MEM_W_EN = 1'b0;
      MEM_R_EN = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin : stimulus
      int op;
      rst = 1'b1; MEM_W_EN = 1'b0; MEM_R_EN = 1'b0;
      Address = '0; WriteData = '0; last_rd = '0;
      for (int i = 0; i < (1 << AW); i++) sram[i] = init_hw(i);
      for (int w = 0; w < WORDS; w++) ref_mem[w] = {init_hw(2*w + 1), init_hw(2*w)};
      sram[2] = 16'h5678;
      sram[3] = 16'h1234;
      ref_mem[1] = 32'h1234_5678;

      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      check("reset_ready", 64'(ready), 64'd1);
      check("reset_readdata", 64'(ReadData), 64'd0);
      check("reset_we_n", 64'(SRAM_WE_N), 64'd1);
      check("reset_oe", 64'(SRAM_DQ_OE), 64'd0);
      check("reset_addr", 64'(SRAM_ADDR), 64'd0);
      idle_cycle();

      issue(1'b1, 1'b0, 32'd1024, 32'hDEAD_BEEF); idle_cycle();
      issue(1'b0, 1'b1, 32'd1028, 32'h0);         idle_cycle();
      issue(1'b1, 1'b1, 32'd1032, 32'hCAFE_F00D); idle_cycle();
      issue(1'b0, 1'b1, 32'd1032, 32'h0);         idle_cycle();
      // Back-to-back: the next request is already present on the cycle after DONE.
      issue(1'b1, 1'b0, 32'd1040, 32'hA5A5_5A5A);
      issue(1'b0, 1'b1, 32'd1040, 32'h0);
      issue(1'b1, 1'b0, 32'd1044, 32'h0BAD_CAFE);
      idle_cycle();
      // Addresses below BASE wrap to the top of the word space.
      issue(1'b1, 1'b0, 32'd1020, 32'h1357_9BDF); idle_cycle();
      issue(1'b0, 1'b1, 32'd1020, 32'h0);         idle_cycle();
      issue(1'b0, 1'b1, 32'd0,    32'h0);         idle_cycle();

      for (int i = 0; i < 10; i++) begin
         check("idle_ready", 64'(ready), 64'd1);
         check("idle_we_n", 64'(SRAM_WE_N), 64'd1);
         check("idle_addr", 64'(SRAM_ADDR), 64'd0);
         @(posedge clk); #1;
      end

      for (int i = 0; i < 40; i++) begin
         op = int'($urandom_range(0, 2));
         issue(op != 0, op != 1, 32'(BASE + 4 * int'($urandom_range(0, 15))), $urandom);
         if ($urandom_range(0, 1) == 1) idle_cycle();
      end
      idle_cycle();

      issue(1'b0, 1'b1, 32'd1028, 32'h0); idle_cycle();
      MEM_W_EN = 1'b1; Address = 32'd1048; WriteData = 32'h1122_3344;
      repeat (3) begin @(posedge clk); #1; end
      check("abort_in_high_addr", 64'(SRAM_ADDR), 64'd13);
      check("abort_in_high_we_n", 64'(SRAM_WE_N), 64'd0);
      rst = 1'b1; MEM_W_EN = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      check("abort_ready", 64'(ready), 64'd1);
      check("abort_we_n", 64'(SRAM_WE_N), 64'd1);
      check("abort_oe", 64'(SRAM_DQ_OE), 64'd0);
      check("abort_readdata", 64'(ReadData), 64'd0);
      check("abort_addr", 64'(SRAM_ADDR), 64'd0);
      last_rd = '0;
      // Both halves were strobed before the abort, so the full word is in the SRAM.
      ref_mem[6] = 32'h1122_3344;
      issue(1'b0, 1'b1, 32'd1048, 32'h0); idle_cycle();

      repeat (3) @(posedge clk);
      check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
